// File: rtl/block_sync_pkg.sv
// Shared types and default thresholds for the multi-lane block synchroniser.
package block_sync_pkg;

  // One-hot lane states so illegal encodings are easy to spot.
  typedef enum logic [3:0] {
    StInvalid  = 4'b0001,
    StTest     = 4'b0010,
    StSlipWait = 4'b0100,
    StLock     = 4'b1000
  } lane_state_e;

  localparam int unsigned DefGoodCnt = 64;
  localparam int unsigned DefWinCnt  = 1024;
  localparam int unsigned DefBadCnt  = 65;

endpackage

// File: rtl/block_sync_lane_rx.sv
// One receive lane: sync-header lock FSM, slip request and saturating slip counter.
module block_sync_lane_rx
  import block_sync_pkg::*;
#(
  parameter int unsigned HEAD_W    = 2,
  parameter int unsigned GOOD_CNT  = DefGoodCnt,
  parameter int unsigned WIN_CNT   = DefWinCnt,
  parameter int unsigned BAD_CNT   = DefBadCnt,
  parameter int unsigned SLIP_WAIT = 2,
  parameter int unsigned STAT_W    = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              signal_v_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic              stat_clr_i,
  output logic              slip_o,
  output logic              lock_o,
  output logic [STAT_W-1:0] slip_cnt_o
);

  if (GOOD_CNT > WIN_CNT || BAD_CNT > WIN_CNT || GOOD_CNT < 1 || BAD_CNT < 1) begin : gen_param_err
    $error("block_sync_lane_rx: illegal GOOD_CNT/BAD_CNT/WIN_CNT combination");
  end

  localparam int unsigned ShW   = $clog2(WIN_CNT + 1);
  localparam int unsigned NvW   = $clog2(BAD_CNT + 1);
  localparam int unsigned WaitW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  lane_state_e      state_q, state_d;
  logic [ShW-1:0]   sh_cnt_q, sh_cnt_d, sh_inc;
  logic [NvW-1:0]   nv_cnt_q, nv_cnt_d, nv_inc;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic [STAT_W-1:0] slip_cnt_q, slip_cnt_d;
  logic             sh_v;
  logic             slip;

  assign sh_v     = ^head_i;
  assign sh_inc   = sh_cnt_q + ShW'(1);
  assign nv_inc   = nv_cnt_q + NvW'(1);
  assign wait_inc = wait_cnt_q + WaitW'(1);

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    nv_cnt_d   = nv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip       = 1'b0;
    if (!signal_v_i) begin
      state_d    = StInvalid;
      sh_cnt_d   = '0;
      nv_cnt_d   = '0;
      wait_cnt_d = '0;
    end else if (valid_i) begin
      unique case (state_q)
        StInvalid: begin
          state_d    = StTest;
          sh_cnt_d   = '0;
          nv_cnt_d   = '0;
          wait_cnt_d = '0;
        end
        StTest: begin
          if (!sh_v) begin
            slip       = 1'b1;
            state_d    = (SLIP_WAIT == 0) ? StTest : StSlipWait;
            sh_cnt_d   = '0;
            nv_cnt_d   = '0;
            wait_cnt_d = '0;
          end else if (sh_inc == ShW'(GOOD_CNT)) begin
            state_d  = StLock;
            sh_cnt_d = '0;
            nv_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end
        StSlipWait: begin
          if (wait_inc == WaitW'(SLIP_WAIT)) begin
            state_d    = StTest;
            sh_cnt_d   = '0;
            nv_cnt_d   = '0;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_inc;
          end
        end
        StLock: begin
          // Loss of lock takes priority over the window restart on the same beat.
          if (!sh_v && nv_inc == NvW'(BAD_CNT)) begin
            slip       = 1'b1;
            state_d    = (SLIP_WAIT == 0) ? StTest : StSlipWait;
            sh_cnt_d   = '0;
            nv_cnt_d   = '0;
            wait_cnt_d = '0;
          end else if (sh_inc == ShW'(WIN_CNT)) begin
            sh_cnt_d = '0;
            nv_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
            if (!sh_v) nv_cnt_d = nv_inc;
          end
        end
        default: begin
          state_d    = StInvalid;
          sh_cnt_d   = '0;
          nv_cnt_d   = '0;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    slip_cnt_d = slip_cnt_q;
    if (stat_clr_i) begin
      slip_cnt_d = slip ? STAT_W'(1) : '0;
    end else if (slip && slip_cnt_q != {STAT_W{1'b1}}) begin
      slip_cnt_d = slip_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= StInvalid;
      sh_cnt_q   <= '0;
      nv_cnt_q   <= '0;
      wait_cnt_q <= '0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      nv_cnt_q   <= nv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign slip_o     = slip;
  assign lock_o     = (state_q == StLock);
  assign slip_cnt_o = slip_cnt_q;

  assert property (@(posedge clk) disable iff (!nreset) $onehot(state_q));
  assert property (@(posedge clk) disable iff (!nreset) slip_o |-> valid_i);

endmodule

// File: rtl/block_sync_multi_rx.sv
// Multi-lane block synchroniser: independent per-lane lock FSMs plus aggregate lock status.
module block_sync_multi_rx
  import block_sync_pkg::*;
#(
  parameter int unsigned NLANE     = 4,
  parameter int unsigned HEAD_W    = 2,
  parameter int unsigned GOOD_CNT  = DefGoodCnt,
  parameter int unsigned WIN_CNT   = DefWinCnt,
  parameter int unsigned BAD_CNT   = DefBadCnt,
  parameter int unsigned SLIP_WAIT = 2,
  parameter int unsigned STAT_W    = 8
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [NLANE-1:0]        signal_v_i,
  input  logic [NLANE-1:0]        valid_i,
  input  logic [NLANE*HEAD_W-1:0] head_i,
  output logic [NLANE-1:0]        slip_o,
  output logic [NLANE-1:0]        lock_o,
  output logic                    all_lock_o,
  input  logic                    stat_clr_i,
  output logic [NLANE*STAT_W-1:0] slip_cnt_o
);

  for (genvar l = 0; l < NLANE; l++) begin : gen_lane
    block_sync_lane_rx #(
      .HEAD_W   (HEAD_W),
      .GOOD_CNT (GOOD_CNT),
      .WIN_CNT  (WIN_CNT),
      .BAD_CNT  (BAD_CNT),
      .SLIP_WAIT(SLIP_WAIT),
      .STAT_W   (STAT_W)
    ) u_lane (
      .clk       (clk),
      .nreset    (nreset),
      .signal_v_i(signal_v_i[l]),
      .valid_i   (valid_i[l]),
      .head_i    (head_i[l*HEAD_W +: HEAD_W]),
      .stat_clr_i(stat_clr_i),
      .slip_o    (slip_o[l]),
      .lock_o    (lock_o[l]),
      .slip_cnt_o(slip_cnt_o[l*STAT_W +: STAT_W])
    );
  end

  assign all_lock_o = &lock_o;

endmodule

// File: tb/tb_block_sync_multi_rx.sv
// Directed bench for block_sync_multi_rx: vector table plus hand-written corner sequences.
module tb_block_sync_multi_rx;

  logic        clk;
  logic        nreset;
  logic [3:0]  signal_v_i;
  logic [3:0]  valid_i;
  logic [7:0]  head_i;
  logic [3:0]  slip_o;
  logic [3:0]  lock_o;
  logic        all_lock_o;
  logic        stat_clr_i;
  logic [31:0] slip_cnt_o;

  int total = 0;
  int bad   = 0;

  block_sync_multi_rx #(
    .NLANE    (4),
    .HEAD_W   (2),
    .GOOD_CNT (64),
    .WIN_CNT  (1024),
    .BAD_CNT  (65),
    .SLIP_WAIT(2),
    .STAT_W   (8)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .signal_v_i(signal_v_i),
    .valid_i   (valid_i),
    .head_i    (head_i),
    .slip_o    (slip_o),
    .lock_o    (lock_o),
    .all_lock_o(all_lock_o),
    .stat_clr_i(stat_clr_i),
    .slip_cnt_o(slip_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst_n;
    logic [3:0] sig;
    logic [3:0] valid;
    logic [7:0] head;
    bit         clr;
    int         reps;
    logic [3:0] exp_slip;
    logic [3:0] exp_lock;
    logic       exp_all;
    bit         chk_cnt;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst_n, logic [3:0] sig, logic [3:0] valid, logic [7:0] head,
                              bit clr, int reps, logic [3:0] exp_slip, logic [3:0] exp_lock,
                              logic exp_all, bit chk_cnt, logic [31:0] exp_cnt);
    vec_t v;
    v.rst_n = rst_n; v.sig = sig; v.valid = valid; v.head = head; v.clr = clr; v.reps = reps;
    v.exp_slip = exp_slip; v.exp_lock = exp_lock; v.exp_all = exp_all;
    v.chk_cnt = chk_cnt; v.exp_cnt = exp_cnt;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, check the combinational slip before the edge, return #1 after the edge.
  task automatic cycle(input bit rst_n, input logic [3:0] sig, input logic [3:0] valid,
                       input logic [7:0] head, input bit clr, input logic [3:0] exp_slip);
    nreset     = rst_n;
    signal_v_i = sig;
    valid_i    = valid;
    head_i     = head;
    stat_clr_i = clr;
    @(negedge clk);
    chk("slip", {28'h0, slip_o}, {28'h0, exp_slip});
    @(posedge clk);
    #1;
  endtask

  // Heads: 55 all good; 75 lane2=11; 45 lane2=00; 57 lane0=11; D5 lane3=11.
  task automatic add_lock_all();
    add(0, 4'hF, 4'hF, 8'h55, 0, 2,  4'h0, 4'h0, 0, 1, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 64, 4'h0, 4'h0, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 1,  4'h0, 4'hF, 1, 1, 32'h0);
  endtask

  initial begin
    nreset = 1'b0; signal_v_i = '0; valid_i = '0; head_i = '0; stat_clr_i = 1'b0;

    // Lock on all lanes, then a one-cycle signal drop on lane 1 while its valid is low.
    add_lock_all();
    add(1, 4'hD, 4'hD, 8'h55, 0, 1,  4'h0, 4'hD, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 1,  4'h0, 4'hD, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 63, 4'h0, 4'hD, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 1,  4'h0, 4'hF, 1, 0, 32'h0);

    // Window hold (64 bad), window restart, loss on 65th bad, coincident slip on lane 3.
    add_lock_all();
    add(1, 4'hF, 4'hF, 8'h57, 0, 64,  4'h0, 4'hF, 1, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 960, 4'h0, 4'hF, 1, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h57, 0, 64,  4'h0, 4'hF, 1, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h57, 0, 1,   4'h1, 4'hE, 0, 1, 32'h0000_0001);
    add(1, 4'hF, 4'hF, 8'h55, 0, 65,  4'h0, 4'hE, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 1,   4'h0, 4'hF, 1, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 828, 4'h0, 4'hF, 1, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'hD5, 0, 64,  4'h0, 4'hF, 1, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'hD5, 0, 1,   4'h8, 4'h7, 0, 1, 32'h0100_0001);

    // TEST slip on lane 2's 10th beat, settle beats carry 00, then 64 fresh goods.
    add(0, 4'hF, 4'hF, 8'h55, 0, 2,  4'h0, 4'h0, 0, 1, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 10, 4'h0, 4'h0, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h75, 0, 1,  4'h4, 4'h0, 0, 1, 32'h0001_0000);
    add(1, 4'hF, 4'hF, 8'h45, 0, 2,  4'h0, 4'h0, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 51, 4'h0, 4'h0, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 1,  4'h0, 4'hB, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 11, 4'h0, 4'hB, 0, 0, 32'h0);
    add(1, 4'hF, 4'hF, 8'h55, 0, 1,  4'h0, 4'hF, 1, 1, 32'h0001_0000);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++)
        cycle(tbl[i].rst_n, tbl[i].sig, tbl[i].valid, tbl[i].head, tbl[i].clr, tbl[i].exp_slip);
      chk($sformatf("lock v%0d", i), {28'h0, lock_o}, {28'h0, tbl[i].exp_lock});
      chk($sformatf("all_lock v%0d", i), {31'h0, all_lock_o}, {31'h0, tbl[i].exp_all});
      if (tbl[i].chk_cnt) chk($sformatf("slip_cnt v%0d", i), slip_cnt_o, tbl[i].exp_cnt);
    end

    // Valid gating on lane 0: bad headers only on its idle cycles.
    cycle(0, 4'hF, 4'hF, 8'h55, 0, 4'h0);
    for (int i = 0; i < 129; i++) begin
      cycle(1, 4'hF, (i % 2 == 0) ? 4'hF : 4'hE, (i % 2 == 0) ? 8'h55 : 8'h57, 0, 4'h0);
      if (i == 127) chk("gated lock 127", {28'h0, lock_o}, 32'h0000_000E);
    end
    chk("gated lock", {28'h0, lock_o}, 32'h0000_000F);
    chk("gated all_lock", {31'h0, all_lock_o}, 32'h1);

    // Slip counter saturation on lane 3, clear coincident with slip, then mid-lock reset.
    cycle(0, 4'hF, 4'hF, 8'hD5, 0, 4'h0);
    cycle(1, 4'hF, 4'hF, 8'hD5, 0, 4'h0);
    for (int k = 0; k < 300; k++) begin
      cycle(1, 4'hF, 4'hF, 8'hD5, 0, 4'h8);
      if (k == 253) chk("cnt 254", slip_cnt_o, 32'hFE00_0000);
      if (k == 254) chk("cnt 255", slip_cnt_o, 32'hFF00_0000);
      cycle(1, 4'hF, 4'hF, 8'hD5, 0, 4'h0);
      cycle(1, 4'hF, 4'hF, 8'hD5, 0, 4'h0);
    end
    chk("cnt sat", slip_cnt_o, 32'hFF00_0000);
    chk("stat lock", {28'h0, lock_o}, 32'h0000_0007);
    cycle(1, 4'hF, 4'hF, 8'hD5, 1, 4'h8);
    chk("clr+slip", slip_cnt_o, 32'h0100_0000);
    cycle(1, 4'hF, 4'hF, 8'hD5, 1, 4'h0);
    chk("clr", slip_cnt_o, 32'h0);
    cycle(0, 4'hF, 4'hF, 8'h55, 0, 4'h0);
    chk("rst lock", {28'h0, lock_o}, 32'h0);
    chk("rst all_lock", {31'h0, all_lock_o}, 32'h0);
    chk("rst slip", {28'h0, slip_o}, 32'h0);
    chk("rst cnt", slip_cnt_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
